mem_access_stage: RTL and testbench

- MEM pipeline stage, directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Turns the latched load/store controls into a handshaked data-bus transaction: request, address accept, data return.
- Aligns and extends load data, replicates store data, raises address-error flags, and stalls the pipeline until the access completes.
- Non-memory instructions pass through combinationally, with zero stall.

---
 rtl/mem_access_stage_pkg.sv | 19 +
 rtl/mem_access_stage_load_align.sv | 26 ++
 rtl/mem_access_stage.sv | 122 ++++++++++++
 tb/tb_mem_access_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared widths, size-mask encodings and FSM states for the MEM stage.
package mem_access_stage_pkg;

  localparam int unsigned DATA_BUS          = 32;
  localparam int unsigned ADDR_BUS          = 32;
  localparam int unsigned MEM_SEL_BUS_WIDTH = 4;

  localparam logic [MEM_SEL_BUS_WIDTH-1:0] MEM_SEL_BYTE = 4'b0001;
  localparam logic [MEM_SEL_BUS_WIDTH-1:0] MEM_SEL_HALF = 4'b0011;
  localparam logic [MEM_SEL_BUS_WIDTH-1:0] MEM_SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    DONE      = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load lane select plus sign/zero extension; purely combinational.
module mem_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [DATA_BUS-1:0]          rdata,
  input  logic [1:0]                   off,
  input  logic [MEM_SEL_BUS_WIDTH-1:0] sel,
  input  logic                         sign_ext,
  output logic [DATA_BUS-1:0]          data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed lane and extend it to the full register width.
  always_comb begin
    byte_lane = rdata[{off, 3'b000} +: 8];
    half_lane = off[1] ? rdata[31:16] : rdata[15:0];
    case (sel)
      MEM_SEL_BYTE: data = {{(DATA_BUS - 8){sign_ext & byte_lane[7]}}, byte_lane};
      MEM_SEL_HALF: data = {{(DATA_BUS - 16){sign_ext & half_lane[15]}}, half_lane};
      default:      data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: turns load/store controls into a handshaked bus
// transaction, aligns load data, replicates store data, and stalls the
// pipeline until the access completes.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_BUS,
  parameter int unsigned DATA_W = DATA_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_next_stage,
  input  logic              mem_read_flag,
  input  logic              mem_write_flag,
  input  logic              mem_sign_ext_flag,
  input  logic [3:0]        mem_sel,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] result_in,
  output logic              data_req,
  output logic              data_wr,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] result_out,
  output logic              adel,
  output logic              ades,
  output logic              stall_request
);

  mem_state_e        state;
  mem_state_e        state_next;
  logic [1:0]        off;
  logic              access;
  logic              misaligned;
  logic              aligned;
  logic              buf_load;
  logic [DATA_W-1:0] load_buf;
  logic [DATA_W-1:0] load_ext;

  assign off = result_in[1:0];

  // Access decode and address-error detection.
  always_comb begin
    access     = mem_read_flag | mem_write_flag;
    misaligned = ((mem_sel == MEM_SEL_HALF) & off[0]) |
                 ((mem_sel == MEM_SEL_WORD) & (off != 2'b00));
    aligned    = access & ~misaligned;
    adel       = mem_read_flag & misaligned;
    ades       = mem_write_flag & misaligned;
  end

  // Bus address and write payload; the EX/MEM register holds these stable while stalled.
  always_comb begin
    data_wr    = mem_write_flag;
    data_addr  = {result_in[ADDR_W-1:2], 2'b00};
    data_wstrb = mem_write_flag ? 4'(mem_sel << off) : 4'b0000;
    case (mem_sel)
      MEM_SEL_BYTE: data_wdata = {4{mem_write_data[7:0]}};
      MEM_SEL_HALF: data_wdata = {2{mem_write_data[15:0]}};
      default:      data_wdata = mem_write_data;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next-state and request; reset suppresses a fresh request from IDLE.
  always_comb begin
    state_next = state;
    data_req   = 1'b0;
    buf_load   = 1'b0;
    case (state)
      IDLE: begin
        if (aligned && !rst) begin
          data_req   = 1'b1;
          state_next = data_addr_ok ? WAIT_DATA : REQ;
        end
      end
      REQ: begin
        data_req = 1'b1;
        if (data_addr_ok) state_next = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (data_data_ok) begin
          buf_load   = mem_read_flag;
          state_next = DONE;
        end
      end
      DONE: begin
        if (!stall_next_stage) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Load buffer captures returned read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           load_buf <= '0;
    else if (buf_load) load_buf <= data_rdata;
  end

  mem_load_align u_load_align (
    .rdata    (load_buf),
    .off      (off),
    .sel      (mem_sel),
    .sign_ext (mem_sign_ext_flag),
    .data     (load_ext)
  );

  // Stall and result selection towards the MEM/WB register.
  always_comb begin
    stall_request = aligned & (state != DONE);
    result_out    = (state == DONE && mem_read_flag && aligned) ? load_ext : result_in;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, random vectors
// against a behavioural model, and hand-written hold/reset sequences.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        stall_next_stage;
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic        mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_write_data;
  logic [31:0] result_in;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] result_out;
  logic        adel;
  logic        ades;
  logic        stall_request;

  int checks   = 0;
  int failures = 0;

  mem_access_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall_next_stage  (stall_next_stage),
    .mem_read_flag     (mem_read_flag),
    .mem_write_flag    (mem_write_flag),
    .mem_sign_ext_flag (mem_sign_ext_flag),
    .mem_sel           (mem_sel),
    .mem_write_data    (mem_write_data),
    .result_in         (result_in),
    .data_req          (data_req),
    .data_wr           (data_wr),
    .data_wstrb        (data_wstrb),
    .data_addr         (data_addr),
    .data_wdata        (data_wdata),
    .data_addr_ok      (data_addr_ok),
    .data_data_ok      (data_data_ok),
    .data_rdata        (data_rdata),
    .result_out        (result_out),
    .adel              (adel),
    .ades              (ades),
    .stall_request     (stall_request)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        sext;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          addr_dly;
    logic [31:0] exp_res;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_adel;
    logic        exp_ades;
    int          exp_stall;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic sext,
                              input logic [3:0] sel, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rdata,
                              input int dly, input logic [31:0] res,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input logic el, input logic es, input int stall);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sext = sext; v.sel = sel; v.addr = addr;
    v.wd = wd; v.rdata = rdata; v.addr_dly = dly; v.exp_res = res;
    v.exp_wdata = wdata; v.exp_wstrb = wstrb; v.exp_adel = el;
    v.exp_ades = es; v.exp_stall = stall;
    return v;
  endfunction

  // Behavioural reference: sizes in bytes, shifts and masks on plain integers.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int nb;
    int off;
    int start;
    longint unsigned val;
    longint unsigned mask;
    bit mis;
    bit aligned;
    r     = v;
    nb    = (v.sel == 4'h1) ? 1 : (v.sel == 4'h3) ? 2 : 4;
    off   = int'(v.addr[1:0]);
    mis   = (v.rd || v.wr) && (off % nb != 0);
    aligned = (v.rd || v.wr) && !mis;
    start = (off / nb) * nb;
    mask  = (64'd1 << (8 * nb)) - 64'd1;
    val   = (64'(v.rdata) >> (8 * start)) & mask;
    if (v.sext && val[8 * nb - 1]) val = val | ~mask;
    r.exp_res = (aligned && v.rd) ? val[31:0] : v.addr;
    for (int i = 0; i < 4; i++) begin
      r.exp_wdata[8 * i +: 8] = v.wd[8 * (i % nb) +: 8];
      r.exp_wstrb[i]          = v.wr && (i >= off) && (i < off + nb);
    end
    r.exp_adel  = v.rd && mis;
    r.exp_ades  = v.wr && mis;
    r.exp_stall = aligned ? v.addr_dly + 2 : 0;
    return r;
  endfunction

  // Apply one instruction, act as the bus (addr_ok after addr_dly, data_ok one cycle later).
  task automatic run_vec(input string name, input vec_t v);
    int stall_cnt = 0;
    int req_cnt   = 0;
    int field_bad = 0;
    int exp_req;
    bit acc_prev  = 0;
    bit finished  = 0;
    exp_req = (v.exp_stall > 0) ? v.addr_dly + 1 : 0;
    @(negedge clk);
    mem_read_flag     = v.rd;
    mem_write_flag    = v.wr;
    mem_sign_ext_flag = v.sext;
    mem_sel           = v.sel;
    mem_write_data    = v.wd;
    result_in         = v.addr;
    data_rdata        = v.rdata;
    data_addr_ok      = 1'b0;
    data_data_ok      = 1'b0;
    stall_next_stage  = 1'b0;
    #1;
    chk({name, "_adel"}, 32'(adel), 32'(v.exp_adel));
    chk({name, "_ades"}, 32'(ades), 32'(v.exp_ades));
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(negedge clk);
        data_data_ok = acc_prev;
        data_addr_ok = 1'b0;
        acc_prev     = 1'b0;
        #1;
      end
      if (data_req) begin
        req_cnt++;
        if (data_wr !== v.wr || data_addr !== {v.addr[31:2], 2'b00} ||
            data_wstrb !== v.exp_wstrb || data_wdata !== v.exp_wdata)
          field_bad++;
        if (req_cnt == v.addr_dly + 1) begin
          data_addr_ok = 1'b1;
          acc_prev     = 1'b1;
        end
      end
      if (!stall_request) begin
        finished = 1;
        break;
      end
      stall_cnt++;
    end
    data_data_ok = 1'b0;
    chk({name, "_finished"}, 32'(finished), 32'd1);
    chk({name, "_stall_cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
    chk({name, "_req_cycles"}, 32'(req_cnt), 32'(exp_req));
    chk({name, "_req_fields_bad"}, 32'(field_bad), 32'd0);
    chk({name, "_result"}, result_out, v.exp_res);
  endtask

  task automatic clear_inputs();
    mem_read_flag     = 1'b0;
    mem_write_flag    = 1'b0;
    mem_sign_ext_flag = 1'b0;
    mem_sel           = 4'h0;
    mem_write_data    = 32'h0;
    data_addr_ok      = 1'b0;
    data_data_ok      = 1'b0;
    stall_next_stage  = 1'b0;
  endtask

  vec_t tbl[14];
  vec_t rv;

  initial begin
    rst        = 1'b1;
    result_in  = 32'h1234_5678;
    data_rdata = 32'h0;
    clear_inputs();

    // Reset state: no request, no stall, pass-through.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_req", 32'(data_req), 32'd0);
    chk("reset_stall", 32'(stall_request), 32'd0);
    chk("reset_result", result_out, 32'h1234_5678);
    rst = 1'b0;

    //            rd wr sx sel    addr          wd            rdata         dly res           wdata         wstrb el es st
    tbl[0]  = mk(1, 0, 0, 4'hF, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 32'h0,        4'h0, 0, 0, 2);
    tbl[1]  = mk(1, 0, 1, 4'h1, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 32'hFFFF_FF80, 32'h0,        4'h0, 0, 0, 2);
    tbl[2]  = mk(1, 0, 0, 4'h1, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 32'h0000_0080, 32'h0,        4'h0, 0, 0, 2);
    tbl[3]  = mk(0, 1, 0, 4'h3, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        3, 32'h0000_0202, 32'hABCD_ABCD, 4'hC, 0, 0, 5);
    tbl[4]  = mk(1, 0, 0, 4'hF, 32'h0000_0101, 32'h0,        32'h1234_5678, 0, 32'h0000_0101, 32'h0,        4'h0, 1, 0, 0);
    tbl[5]  = mk(0, 1, 0, 4'hF, 32'h0000_0102, 32'h1111_1111, 32'h0,        0, 32'h0000_0102, 32'h1111_1111, 4'h0, 0, 1, 0);
    tbl[6]  = mk(1, 0, 1, 4'h3, 32'h0000_0102, 32'h0,        32'h8001_1234, 0, 32'hFFFF_8001, 32'h0,        4'h0, 0, 0, 2);
    tbl[7]  = mk(1, 0, 0, 4'h3, 32'h0000_0100, 32'h0,        32'h1234_F00D, 0, 32'h0000_F00D, 32'h0,        4'h0, 0, 0, 2);
    tbl[8]  = mk(0, 1, 0, 4'h1, 32'h0000_0301, 32'h1234_56A5, 32'h0,        0, 32'h0000_0301, 32'hA5A5_A5A5, 4'h2, 0, 0, 2);
    tbl[9]  = mk(0, 0, 0, 4'hF, 32'hCAFE_F00D, 32'h0,        32'h0,        0, 32'hCAFE_F00D, 32'h0,        4'h0, 0, 0, 0);
    tbl[10] = mk(1, 0, 1, 4'h1, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0, 32'h0000_007F, 32'h0,        4'h0, 0, 0, 2);
    tbl[11] = mk(0, 1, 0, 4'hF, 32'h0000_0104, 32'h1122_3344, 32'h0,        1, 32'h0000_0104, 32'h1122_3344, 4'hF, 0, 0, 3);
    tbl[12] = mk(1, 0, 1, 4'h3, 32'h0000_0103, 32'h0,        32'hFFFF_FFFF, 0, 32'h0000_0103, 32'h0,        4'h0, 1, 0, 0);
    tbl[13] = mk(1, 0, 1, 4'h3, 32'h0000_0402, 32'h0,        32'h7FFF_8000, 2, 32'h0000_7FFF, 32'h0,        4'h0, 0, 0, 4);

    for (int i = 0; i < 14; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // Randomized instructions checked against the behavioural model.
    for (int i = 0; i < 40; i++) begin
      int k;
      k        = int'($urandom_range(0, 3));
      rv.rd    = (k == 1 || k == 3);
      rv.wr    = (k == 2);
      rv.sext  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       rv.sel = 4'h1;
        1:       rv.sel = 4'h3;
        default: rv.sel = 4'hF;
      endcase
      rv.addr     = $urandom;
      rv.wd       = $urandom;
      rv.rdata    = $urandom;
      rv.addr_dly = int'($urandom_range(0, 3));
      run_vec($sformatf("rnd%0d", i), model(rv));
    end

    // Load completes while MEM/WB holds: stay in DONE, no re-issue, result stable.
    @(negedge clk);
    clear_inputs();
    mem_read_flag    = 1'b1;
    mem_sel          = 4'hF;
    result_in        = 32'h0000_0100;
    data_rdata       = 32'h55AA_55AA;
    stall_next_stage = 1'b1;
    #1;
    chk("hold_first_req", 32'(data_req), 32'd1);
    data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    @(negedge clk);
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold%0d_req", c), 32'(data_req), 32'd0);
      chk($sformatf("hold%0d_stall", c), 32'(stall_request), 32'd0);
      chk($sformatf("hold%0d_result", c), result_out, 32'h55AA_55AA);
      if (c == 2) stall_next_stage = 1'b0;
      else @(negedge clk);
    end
    @(negedge clk);
    #1;
    chk("release_idle_req", 32'(data_req), 32'd1);
    chk("release_idle_stall", 32'(stall_request), 32'd1);
    clear_inputs();

    // Reset during WAIT_DATA: request drops at once, stale data_ok ignored.
    @(negedge clk);
    mem_read_flag = 1'b1;
    mem_sel       = 4'hF;
    result_in     = 32'h0000_0100;
    data_rdata    = 32'h7777_7777;
    #1;
    data_addr_ok  = 1'b1;
    @(negedge clk);
    data_addr_ok  = 1'b0;
    #1;
    chk("wait_stall", 32'(stall_request), 32'd1);
    chk("wait_req", 32'(data_req), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_req", 32'(data_req), 32'd0);
    clear_inputs();
    #1;
    rst = 1'b0;
    @(negedge clk);
    data_data_ok = 1'b1;
    data_rdata   = 32'h9999_9999;
    #1;
    chk("stale_ok_stall", 32'(stall_request), 32'd0);
    chk("stale_ok_req", 32'(data_req), 32'd0);
    @(negedge clk);
    data_data_ok = 1'b0;
    run_vec("after_rst", mk(1, 0, 0, 4'hF, 32'h0000_0108, 32'h0, 32'h0BAD_F00D, 0,
                            32'h0BAD_F00D, 32'h0, 4'h0, 0, 0, 2));

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
